// File: rtl/station_dest_pkg.sv
// Shared types and constants for the station destination controller.
package station_dest_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;
  localparam int         DEST_W  = 6;

endpackage

// File: rtl/station_dest_ctrl_piezo_drv.sv
// Piezo buzzer driver: square wave with BUZZ_HALF-cycle half period while enabled,
// both outputs held low when disabled.
module piezo_drv #(
  parameter int BUZZ_HALF = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam int CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             buzz_q;
  logic             en_q;

  // en_q delays the enable so that losing it clears both outputs on the next edge
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q  <= '0;
      buzz_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        buzz_q <= ~buzz_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = en_q & ~buzz_q;

endmodule

// File: rtl/station_dest_ctrl.sv
// Destination controller: latches a GO destination, counts passed stations and
// stops the robot when the destination barcode is read.
module station_dest_ctrl
  import station_dest_pkg::*;
#(
  parameter int BUZZ_HALF = 12500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic [7:0]  ID,
  input  logic        ID_vld,
  output logic        clr_ID_vld,
  input  logic        OK2Move,
  output logic        go,
  output logic        in_transit,
  output logic        dest_reached,
  output logic        buzz,
  output logic        buzz_n,
  output logic [3:0]  stn_cnt
);

  state_t            state_q, state_d;
  logic [DEST_W-1:0] dest_id_q, dest_id_d;
  logic [3:0]        stn_cnt_q, stn_cnt_d;
  logic              dest_reached_q, dest_reached_d;

  // Reader only validates IDs with 00 in the top bits; opcode payload above 5:0 is unused
  logic unused_bits;
  assign unused_bits = ^{ID[7:6], cmd[13:6]};

  always_comb begin
    state_d        = state_q;
    dest_id_d      = dest_id_q;
    stn_cnt_d      = stn_cnt_q;
    dest_reached_d = 1'b0;
    if (cmd_rdy) begin
      // A pending command wins; any simultaneous ID is dropped unexamined
      case (cmd[15:14])
        OP_GO: begin
          dest_id_d = cmd[DEST_W-1:0];
          stn_cnt_d = 4'd0;
          state_d   = MOVE;
        end
        OP_STOP: state_d = IDLE;
        default: ;
      endcase
    end else if (ID_vld && (state_q == MOVE)) begin
      if (ID[DEST_W-1:0] == dest_id_q) begin
        state_d        = IDLE;
        dest_reached_d = 1'b1;
      end else if (stn_cnt_q != 4'hF) begin
        stn_cnt_d = stn_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dest_id_q      <= '0;
      stn_cnt_q      <= 4'd0;
      dest_reached_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dest_id_q      <= dest_id_d;
      stn_cnt_q      <= stn_cnt_d;
      dest_reached_q <= dest_reached_d;
    end
  end

  // Requests seen during reset are left pending and handled from IDLE afterwards
  assign clr_cmd_rdy  = cmd_rdy & ~rst;
  assign clr_ID_vld   = ID_vld & ~rst;
  assign in_transit   = (state_q == MOVE);
  assign go           = in_transit & OK2Move;
  assign dest_reached = dest_reached_q;
  assign stn_cnt      = stn_cnt_q;

  piezo_drv #(
    .BUZZ_HALF(BUZZ_HALF)
  ) u_piezo (
    .clk    (clk),
    .rst    (rst),
    .en     (in_transit & ~OK2Move),
    .buzz   (buzz),
    .buzz_n (buzz_n)
  );

endmodule

// File: tb/tb_station_dest_ctrl.sv
// Self-checking bench for station_dest_ctrl: directed scenarios plus randomized
// traffic against a trip-level reference model.
module tb_station_dest_ctrl;

  localparam int BH = 4;

  logic        clk = 1'b0;
  logic        rst, cmd_rdy, ID_vld, OK2Move;
  logic [15:0] cmd;
  logic [7:0]  ID;
  logic        clr_cmd_rdy, clr_ID_vld, go, in_transit, dest_reached, buzz, buzz_n;
  logic [3:0]  stn_cnt;

  station_dest_ctrl #(.BUZZ_HALF(BH)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
    .go(go), .in_transit(in_transit), .dest_reached(dest_reached),
    .buzz(buzz), .buzz_n(buzz_n), .stn_cnt(stn_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit verbose  = 1'b1;

  // Reference model: the trip as a whole, not the state machine
  bit       m_moving = 1'b0;
  bit [5:0] m_dest   = '0;
  int       m_cnt    = 0;
  bit       m_pulse  = 1'b0;
  int       m_run    = 0;   // consecutive edges with the buzzer enabled

  logic obs_clr_cmd, obs_clr_id, obs_go;
  logic exp_clr_cmd, exp_clr_id, exp_go;

  function automatic logic [10:0] exp_vec();
    logic eb, ebn;
    eb  = (m_run > 0) && (((m_run / BH) % 2) == 1);
    ebn = (m_run > 0) && !eb;
    return {exp_clr_cmd, exp_clr_id, exp_go, m_moving, m_pulse, eb, ebn, 4'(m_cnt)};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {obs_clr_cmd, obs_clr_id, obs_go, in_transit, dest_reached, buzz, buzz_n, stn_cnt};
  endfunction

  task automatic drive(input logic r, input logic cr, input logic [15:0] c,
                       input logic iv, input logic [7:0] id, input logic ok);
    @(negedge clk);
    rst = r; cmd_rdy = cr; cmd = c; ID_vld = iv; ID = id; OK2Move = ok;
    if (verbose && (cr || iv))
      $display("t=%0t rst=%b cmd_rdy=%b cmd=%h ID_vld=%b ID=%h OK2Move=%b",
               $time, r, cr, c, iv, id, ok);
    #1;
    obs_clr_cmd = clr_cmd_rdy; obs_clr_id = clr_ID_vld; obs_go = go;
    exp_clr_cmd = cr & ~r;     exp_clr_id = iv & ~r;    exp_go = m_moving & ok;
    @(posedge clk);
    if (r) begin
      m_moving = 1'b0; m_dest = '0; m_cnt = 0; m_pulse = 1'b0; m_run = 0;
    end else begin
      m_run   = (m_moving && !ok) ? m_run + 1 : 0;
      m_pulse = 1'b0;
      if (cr) begin
        if (c[15:14] == 2'b01) begin
          m_moving = 1'b1; m_dest = c[5:0]; m_cnt = 0;
        end else if (c[15:14] == 2'b00) begin
          m_moving = 1'b0;
        end
      end else if (iv && m_moving) begin
        if (id[5:0] == m_dest) begin
          m_moving = 1'b0; m_pulse = 1'b1;
        end else if (m_cnt < 15) begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 16'h4015, 1'b1, 8'h15, 1'b1);
    n_checks++;
    if ({obs_clr_cmd, obs_clr_id} !== 2'b00)
      $display("FAIL reset_clears: got %b required 00", {obs_clr_cmd, obs_clr_id});
    else n_pass++;
    n_checks++;
    if ({in_transit, dest_reached, buzz, buzz_n, stn_cnt} !== 8'h00)
      $display("FAIL reset_state: got %h required 00", {in_transit, dest_reached, buzz, buzz_n, stn_cnt});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_idle: got %b required %b", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_trip();
    drive(1'b0, 1'b1, 16'h4015, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if ({obs_clr_cmd, in_transit} !== 2'b11)
      $display("FAIL trip_go: clr/in_transit got %b required 11", {obs_clr_cmd, in_transit});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if (obs_clr_cmd !== 1'b0) $display("FAIL trip_clr_one_cycle: got %b required 0", obs_clr_cmd);
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h03, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h07, 1'b1);
    n_checks++;
    if ({in_transit, stn_cnt} !== 5'b1_0010)
      $display("FAIL trip_count: in_transit/stn_cnt got %b required 10010", {in_transit, stn_cnt});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h15, 1'b1);
    n_checks++;
    if ({dest_reached, in_transit} !== 2'b10)
      $display("FAIL trip_arrive: dest_reached/in_transit got %b required 10", {dest_reached, in_transit});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if (dest_reached !== 1'b0) $display("FAIL trip_pulse_len: got %b required 0", dest_reached);
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL trip_vec: got %b required %b", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_buzzer();
    drive(1'b0, 1'b1, 16'h4015, 1'b0, 8'h0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL buzz_cycle%0d: got %b required %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i == BH) begin
        n_checks++;
        if ({obs_go, buzz, buzz_n} !== 3'b010)
          $display("FAIL buzz_first_toggle: go/buzz/buzz_n got %b required 010", {obs_go, buzz, buzz_n});
        else n_pass++;
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if ({obs_go, buzz, buzz_n} !== 3'b100)
      $display("FAIL buzz_off: go/buzz/buzz_n got %b required 100", {obs_go, buzz, buzz_n});
    else n_pass++;
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0, 1'b1);
  endtask

  task automatic test_stop();
    drive(1'b0, 1'b1, 16'h4015, 1'b0, 8'h0, 1'b1);
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if ({in_transit, dest_reached} !== 2'b00)
      $display("FAIL stop: in_transit/dest_reached got %b required 00", {in_transit, dest_reached});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h15, 1'b1);
    n_checks++;
    if ({obs_clr_id, in_transit, dest_reached} !== 3'b100)
      $display("FAIL stop_late_id: clr/in_transit/dest_reached got %b required 100",
               {obs_clr_id, in_transit, dest_reached});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 1'b1, 16'h4015, 1'b0, 8'h0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h01, 1'b1);
    drive(1'b0, 1'b1, 16'h4009, 1'b1, 8'h15, 1'b1);
    n_checks++;
    if ({obs_clr_cmd, obs_clr_id, in_transit, dest_reached, stn_cnt} !== 8'b1110_0000)
      $display("FAIL simul: got %b required 11100000",
               {obs_clr_cmd, obs_clr_id, in_transit, dest_reached, stn_cnt});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 8'h09, 1'b1);
    n_checks++;
    if ({dest_reached, in_transit} !== 2'b10)
      $display("FAIL simul_new_dest: dest_reached/in_transit got %b required 10", {dest_reached, in_transit});
    else n_pass++;
  endtask

  task automatic test_saturate_reset();
    drive(1'b0, 1'b1, 16'h4015, 1'b0, 8'h0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 16'h0, 1'b1, 8'(i), 1'b1);
    n_checks++;
    if ({in_transit, stn_cnt} !== 5'b1_1111)
      $display("FAIL saturate: in_transit/stn_cnt got %b required 11111", {in_transit, stn_cnt});
    else n_pass++;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    n_checks++;
    if ({in_transit, dest_reached, buzz, buzz_n, stn_cnt} !== 8'h00)
      $display("FAIL mid_trip_reset: got %h required 00", {in_transit, dest_reached, buzz, buzz_n, stn_cnt});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if (obs_go !== 1'b0) $display("FAIL reset_go: got %b required 0", obs_go);
    else n_pass++;
  endtask

  task automatic test_ignored_opcode();
    drive(1'b0, 1'b1, 16'hC015, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if ({obs_clr_cmd, in_transit} !== 2'b10)
      $display("FAIL ignored_op: clr/in_transit got %b required 10", {obs_clr_cmd, in_transit});
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    n_checks++;
    if ({obs_clr_cmd, in_transit} !== 2'b00)
      $display("FAIL ignored_op_after: clr/in_transit got %b required 00", {obs_clr_cmd, in_transit});
    else n_pass++;
  endtask

  task automatic test_random();
    logic        r, cr, iv, ok;
    logic [15:0] c;
    logic [7:0]  id;
    verbose = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      cr = ($urandom_range(0, 99) < 20);
      iv = ($urandom_range(0, 99) < 40);
      ok = ($urandom_range(0, 99) < 70);
      c  = {2'($urandom), 11'($urandom), 3'($urandom)};
      id = {2'($urandom), 3'b000, 3'($urandom)};
      drive(r, cr, c, iv, id, ok);
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_%0d: got %b required %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; ID_vld = 1'b0; ID = '0; OK2Move = 1'b1;
    test_reset();
    test_trip();
    test_buzzer();
    test_stop();
    test_simultaneous();
    test_saturate_reset();
    test_ignored_opcode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/station_dest_ctrl.md
# station_dest_ctrl

Destination controller directly downstream of the barcode reader. Accepts 16-bit movement commands from the command receiver and latches a destination station ID. While the robot is in transit, it consumes each validated barcode ID and clears it. It drives `go` and `in_transit` to the motion core and stops the robot when the destination station is read. A piezo buzzer output signals a blocked path while the robot is in transit.

## Interface
Parameters:
- `BUZZ_HALF`, default 12500: buzzer half-period in clk cycles (2 kHz at 50 MHz).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `cmd` in 16: command word, valid while `cmd_rdy` is high.
- `cmd_rdy` in 1: level, held high by the command receiver until `clr_cmd_rdy`.
- `clr_cmd_rdy` out 1: combinational, one cycle; acknowledges `cmd`.
- `ID` in 8: station ID from the barcode reader.
- `ID_vld` in 1: level, held high until `clr_ID_vld`.
- `clr_ID_vld` out 1: combinational, one cycle; acknowledges `ID`.
- `OK2Move` in 1: high when no obstacle is present.
- `go` out 1: `in_transit & OK2Move`, combinational.
- `in_transit` out 1: high in MOVE state.
- `dest_reached` out 1: registered one-cycle pulse.
- `buzz` out 1, `buzz_n` out 1: complementary piezo drive.
- `stn_cnt` out 4: stations passed in the current trip, saturates at 15.

## Operation
- Command decode, `cmd[15:14]`:
  - 2'b01 is GO; destination = `cmd[5:0]`.
  - 2'b00 is STOP.
  - 2'b10 and 2'b11 are ignored but still acknowledged.
- States (`state_t`): IDLE, MOVE.
- IDLE:
  - `cmd_rdy` → `clr_cmd_rdy`=1 that cycle.
  - GO → latch `dest_ID`, clear `stn_cnt`, go to MOVE.
  - Other opcodes → stay in IDLE.
  - `ID_vld` in IDLE → `clr_ID_vld`=1 and the ID is discarded.
- MOVE:
  - `ID_vld` with `cmd_rdy` low → `clr_ID_vld`=1.
  - If `ID[5:0]==dest_ID` → IDLE, and `dest_reached` pulses on the next cycle.
  - Otherwise `stn_cnt` += 1 (saturating at 15) and the block stays in MOVE.
  - `ID[7:6]` is ignored, since the reader only validates IDs with 00 there.
- MOVE, `cmd_rdy` → `clr_cmd_rdy`=1:
  - GO → reload `dest_ID`, clear `stn_cnt`, stay in MOVE.
  - STOP → IDLE with no `dest_reached` pulse.
  - Unknown opcode → stay in MOVE.
- Simultaneous `cmd_rdy` and `ID_vld` in MOVE: both clears assert. The command is processed and the ID is discarded (no compare, no count).
- Buzzer:
  - Enabled when `in_transit & ~OK2Move`.
  - The counter counts 0..BUZZ_HALF-1; on wrap, `buzz` toggles.
  - `buzz_n` = `~buzz` while enabled.
  - When disabled: counter=0, `buzz`=0, `buzz_n`=0 (piezo off).
- Reset values: state=IDLE, `dest_ID`=0, `stn_cnt`=0, `dest_reached`=0, `buzz`=0, buzz counter=0. All combinational outputs are therefore 0.

## Timing
- Clear latency: `clr_*` is high in the same cycle the request is seen. Upstream drops its valid on the next edge, so each ID/command is consumed exactly once.
- `in_transit` rises on the edge after a GO is accepted; `go` follows `OK2Move` with zero latency.
- Arrival: match seen at cycle t → state=IDLE and `dest_reached`=1 at t+1; `dest_reached`=0 at t+2.
- Buzzer: the first toggle occurs BUZZ_HALF cycles after the enable rises. Enable loss returns the outputs to 0 on the next edge.
- Reset while in MOVE:
  - The next edge returns the block to IDLE.
  - `go` falls combinationally with `in_transit`.
  - Pending `cmd_rdy`/`ID_vld` are handled normally from IDLE.

## Structure
- `station_dest_pkg`: `state_t`, opcode constants OP_STOP=2'b00 and OP_GO=2'b01, `DEST_W`=6.
- Sub-module `piezo_drv` contains the buzzer counter, toggle and enable, parameterised by BUZZ_HALF.
- The top level holds the FSM, `dest_ID`, `stn_cnt` and the `dest_reached` register.

## Test plan
- Reset, then GO `cmd`=16'h4015 → `clr_cmd_rdy` is one cycle, `in_transit`=1. Then IDs 8'h03 and 8'h07 → `stn_cnt`=2, still in MOVE. Then ID 8'h15 → `dest_reached` pulses once, back in IDLE.
- In MOVE with `OK2Move`=0 and BUZZ_HALF=4 → `go`=0, `buzz` toggles every 4 cycles, `buzz_n`=`~buzz`. Raising `OK2Move` → both 0 on the next edge.
- In MOVE, STOP `cmd`=16'h0000 → back in IDLE, no `dest_reached`. A later ID equal to `dest_ID` is only cleared.
- `cmd_rdy` (GO 8'h09) and `ID_vld` (ID=old dest 8'h15) arrive in the same cycle → both clears assert, stays in MOVE, dest=8'h09, no `dest_reached`.
- 16 non-matching IDs → `stn_cnt` saturates at 15. Assert `rst` mid-trip → IDLE and all outputs 0 next cycle.
- Ignored opcode 16'hC015 in IDLE → acknowledged with one-cycle `clr_cmd_rdy`, `in_transit` stays 0.
